// File: rtl/rf_dump_pkg.sv
// rf_dump_pkg: shared state encoding and constants for the register-file dump engine.
package rf_dump_pkg;

    localparam int RF_NREG      = 32;
    localparam int RF_CKSUM_IDX = 32;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        HOLD  = 3'd2,
        CKSUM = 3'd3,
        DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/rf_dump_obuf.sv
// rf_dump_obuf: single-entry output holding register for the dump stream.
// A load takes priority over a same-cycle handshake, so a new word can be
// presented back-to-back (used for the checksum word).
module rf_dump_obuf #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [DW-1:0] ld_data,
    input  logic [AW:0]   ld_idx,
    input  logic          out_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic [AW:0]   out_idx
);

    // Capture on load, drop valid after the handshake, hold data otherwise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= ld_data;
            out_idx   <= ld_idx;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/rf_dump.sv
// rf_dump: walks the register file debug read port x0..x31 on a start pulse
// and streams each value with its index on a valid/ready interface.
// Optional feature macro: RF_DUMP_CKSUM_EN appends an XOR checksum word (idx 32).
module rf_dump
    import rf_dump_pkg::*;
#(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] reg_sel,
    input  logic [DW-1:0] reg_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [AW:0]   out_idx
);

    state_t        state, nxt;
    logic [AW-1:0] idx;
    logic          hs;
    logic          last;
    logic          load;
    logic [DW-1:0] ld_data;
    logic [AW:0]   ld_idx;

    assign hs      = out_valid && out_ready;
    assign last    = (idx == {AW{1'b1}});
    assign reg_sel = idx;
    assign busy    = (state == FETCH) || (state == HOLD) || (state == CKSUM);
    assign done    = (state == DONE);

`ifdef RF_DUMP_CKSUM_EN
    logic [DW-1:0] acc;

    // Running XOR of every captured word; cleared when a dump is accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            acc <= '0;
        else if (state == IDLE && start)
            acc <= '0;
        else if (state == FETCH)
            acc <= acc ^ reg_data;
    end
`endif

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= nxt;
    end

    // Register index: restarts at x0 on accept, steps after each accepted word, never wraps.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            idx <= '0;
        else if (state == IDLE && start)
            idx <= '0;
        else if (state == HOLD && hs && !last)
            idx <= idx + AW'(1);
    end

    // Next-state and output-buffer load control.
    always_comb begin
        nxt     = state;
        load    = 1'b0;
        ld_data = reg_data;
        ld_idx  = {1'b0, idx};
        case (state)
            IDLE:  if (start) nxt = FETCH;
            FETCH: begin
                load = 1'b1;
                nxt  = HOLD;
            end
            HOLD: begin
                if (hs) begin
                    if (!last) begin
                        nxt = FETCH;
                    end else begin
`ifdef RF_DUMP_CKSUM_EN
                        nxt     = CKSUM;
                        load    = 1'b1;
                        ld_data = acc;
                        ld_idx  = (AW+1)'(RF_CKSUM_IDX);
`else
                        nxt = DONE;
`endif
                    end
                end
            end
`ifdef RF_DUMP_CKSUM_EN
            CKSUM: if (hs) nxt = DONE;
`endif
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    rf_dump_obuf #(.DW(DW), .AW(AW)) u_obuf (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .ld_data   (ld_data),
        .ld_idx    (ld_idx),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_idx   (out_idx)
    );

endmodule

// File: tb/tb_rf_dump.sv
// tb_rf_dump: directed bench for rf_dump with a behavioural register file.
// Honours RF_DUMP_CKSUM_EN to expect the extra checksum word.
module tb_rf_dump;

    localparam int DW = 32;
    localparam int AW = 5;
`ifdef RF_DUMP_CKSUM_EN
    localparam int NW     = 33;
    localparam int DONE_D = 65;
`else
    localparam int NW     = 32;
    localparam int DONE_D = 64;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          out_ready = 1'b0;
    logic          busy, done, out_valid;
    logic [AW-1:0] reg_sel;
    logic [DW-1:0] reg_data, out_data;
    logic [AW:0]   out_idx;

    logic [DW-1:0] rf     [32];
    logic [DW-1:0] pl_tbl [32];
    logic          pl_go = 1'b0;
    logic          we = 1'b0;
    logic [AW-1:0] wa = '0;
    logic [DW-1:0] wd = '0;
    logic [DW-1:0] exp_w  [34];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    // Register file: writes commit on the rising edge, read is combinational, x0 reads 0.
    always_ff @(posedge clk) begin
        if (pl_go)   rf <= pl_tbl;
        else if (we) rf[wa] <= wd;
    end
    assign reg_data = (reg_sel == '0) ? '0 : rf[reg_sel];

    rf_dump #(.DW(DW), .AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .reg_sel   (reg_sel),
        .reg_data  (reg_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    // kind 0: xN = 0x1000_0000+N; 1: xN = N; 2: xN = N with x31 = all ones.
    task automatic preload(input int kind);
        logic [DW-1:0] x;
        for (int n = 0; n < 32; n++) begin
            if (kind == 0) pl_tbl[n] = 32'h1000_0000 + n;
            else           pl_tbl[n] = n;
        end
        if (kind == 2) pl_tbl[31] = 32'hFFFF_FFFF;
        x = '0;
        for (int n = 0; n < 32; n++) begin
            exp_w[n] = (n == 0) ? '0 : pl_tbl[n];
            x = x ^ exp_w[n];
        end
        exp_w[32] = x;
        exp_w[33] = '0;
        @(negedge clk) pl_go = 1'b1;
        @(negedge clk) pl_go = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},  busy,      0);
        check({tag, "_done"},  done,      0);
        check({tag, "_valid"}, out_valid, 0);
        check({tag, "_data"},  out_data,  0);
        check({tag, "_idx"},   out_idx,   0);
        check({tag, "_sel"},   reg_sel,   0);
    endtask

    // rmode: 0 ready high, 1 pseudo-random ready. wmode 1: writes during FETCH of x5 / x6.
    // smode 1: extra start pulses mid-dump. rst_at >= 0: reset while holding that word.
    task automatic run_dump(input int rmode, input int wmode, input int smode, input int rst_at);
        int            nwords = 0;
        int            ndone  = 0;
        int            f0     = -1;
        int            dcyc   = -1;
        bit            stall  = 0;
        bit            aborted = 0;
        logic [DW-1:0] sd = '0;
        logic [AW:0]   si = '0;
        logic [15:0]   lfsr = 16'hACE1;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        check("busy_after_start", busy, 1);
        check("valid_in_first_fetch", out_valid, 0);
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (f0 < 0 && busy && !out_valid && reg_sel == '0) f0 = cyc;
            if (stall) begin
                check("stall_valid", out_valid, 1);
                check("stall_data",  out_data,  sd);
                check("stall_idx",   out_idx,   si);
            end
            we    = 1'b0;
            start = 1'b0;
            if (wmode == 1 && busy && !out_valid) begin
                if (reg_sel == 5) begin we = 1'b1; wa = 5; wd = 32'hDEAD_BEEF; end
                if (reg_sel == 6) begin we = 1'b1; wa = 7; wd = 32'h7777_0007; end
            end
            if (smode == 1 && ((busy && !out_valid && reg_sel == 10) ||
                               (out_valid && out_idx == 12)))
                start = 1'b1;
            if (rst_at >= 0 && out_valid && out_idx == rst_at) begin
                rst = 1'b0;
                #1 check_reset_outputs("rst_mid");
                @(negedge clk) check_reset_outputs("rst_next");
                rst = 1'b1;
                @(negedge clk) check("rst_no_done", done, 0);
                check("rst_idle", busy, 0);
                aborted = 1;
                break;
            end
            out_ready = (rmode == 0) ? 1'b1 : lfsr[0];
            lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            if (out_valid && out_ready) begin
                if (nwords == 0) check("first_word_latency", cyc - f0, 1);
                if (nwords < NW) begin
                    check("word_idx",  out_idx,  nwords);
                    check("word_data", out_data, exp_w[nwords]);
                end
                nwords++;
            end
            stall = out_valid && !out_ready;
            sd    = out_data;
            si    = out_idx;
            if (done) begin
                ndone++;
                if (dcyc < 0) dcyc = cyc;
                check("busy_low_at_done", busy, 0);
            end
            if (dcyc >= 0 && cyc >= dcyc + 3) break;
            @(negedge clk);
        end
        we = 1'b0;
        start = 1'b0;
        if (!aborted) begin
            check("word_count", nwords, NW);
            check("done_count", ndone, 1);
            if (rmode == 0) check("done_latency", dcyc - f0, DONE_D);
        end
    endtask

    initial begin
        // Reset state.
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("post_release");

        // Full dump, ready high.
        preload(0);
        run_dump(0, 0, 0, -1);

        // Same data under pseudo-random backpressure.
        preload(0);
        run_dump(1, 0, 0, -1);

        // Writes in FETCH cycles: x5 keeps its old value; x7 written before its fetch shows the new one.
        preload(0);
        exp_w[7] = 32'h7777_0007;
        run_dump(0, 1, 0, -1);

        // Start pulses while busy are ignored.
        preload(0);
        run_dump(0, 0, 1, -1);

        // Reset while holding word 17, then a fresh dump from x0.
        preload(0);
        run_dump(0, 0, 0, 17);
        run_dump(0, 0, 0, -1);

`ifdef RF_DUMP_CKSUM_EN
        // Checksum over xN = N is zero; with x31 all ones it is 0x1F ^ 0xFFFF_FFFF.
        preload(1);
        check("cksum_model_zero", exp_w[32], 32'h0000_0000);
        run_dump(0, 0, 0, -1);
        preload(2);
        check("cksum_model_ones", exp_w[32], 32'hFFFF_FFE0);
        run_dump(1, 0, 0, -1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
